// File: rtl/serial_link_phy_tx_mc.sv
// Multi-channel source-synchronous TX PHY: shared divider/phase shifter, DDR/SDR lanes, training sequencer.
// Lane data and forwarded clock are registered (2 cycles acceptance-to-pad); ready_o only on a beat boundary.
module serial_link_phy_tx_mc #(
   parameter int NumChannels = 2,
   parameter int NumLanes    = 8,
   parameter int MaxClkDiv   = 32,
   parameter int TrainLenW   = 8,
   localparam int CntW       = $clog2(MaxClkDiv) + 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [CntW-1:0]                   cfg_clk_div_i,
   input  logic [CntW-1:0]                   cfg_shift_start_i,
   input  logic [CntW-1:0]                   cfg_shift_end_i,
   input  logic                              cfg_ddr_en_i,
   input  logic [NumChannels-1:0]            cfg_chan_en_i,
   input  logic                              train_req_i,
   input  logic [TrainLenW-1:0]              train_len_i,
   input  logic [NumChannels*2*NumLanes-1:0] data_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   output logic [NumChannels-1:0]            ddr_clk_o,
   output logic [NumChannels*NumLanes-1:0]   ddr_o,
   output logic                              busy_o,
   output logic                              train_done_o
);

   localparam int BeatW = 2 * NumLanes;
   localparam logic [NumLanes-1:0] Pat55 = NumLanes'({((NumLanes + 1) / 2){2'b01}});
   localparam logic [NumLanes-1:0] PatAA = ~Pat55;

   typedef enum logic [1:0] {IDLE, SEND, TRAIN} state_e;

   state_e                          state_q, state_d;
   logic [CntW-1:0]                 cnt_q, cnt_d;
   logic [CntW-1:0]                 div_q, div_d;
   logic [CntW-1:0]                 start_q, start_d;
   logic [CntW-1:0]                 end_q, end_d;
   logic                            ddr_en_q, ddr_en_d;
   logic [NumChannels-1:0]          chan_en_q, chan_en_d;
   logic [TrainLenW-1:0]            tcnt_q, tcnt_d;
   logic                            tphase_q, tphase_d;
   logic [NumChannels*BeatW-1:0]    beat_q, beat_d;
   logic                            clk_q, clk_d;
   logic [NumChannels-1:0]          ddr_clk_q, ddr_clk_d;
   logic [NumChannels*NumLanes-1:0] ddr_q, ddr_d;
   logic                            busy_q;
   logic                            done_q, done_d;

   logic [CntW-1:0]      div_even;
   logic [CntW-1:0]      half;
   logic [TrainLenW-1:0] tlen;
   logic                 wrap, active, latch, ready, sel_hi;

   assign div_even = cfg_clk_div_i & ~CntW'(1);
   assign half     = div_q >> 1;
   assign wrap     = (cnt_q == div_q - CntW'(1));
   assign active   = (state_q != IDLE);
   assign tlen     = (train_len_i == '0) ? TrainLenW'(1) : train_len_i;

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      start_d   = start_q;
      end_d     = end_q;
      ddr_en_d  = ddr_en_q;
      chan_en_d = chan_en_q;
      tcnt_d    = tcnt_q;
      tphase_d  = tphase_q;
      beat_d    = beat_q;
      done_d    = 1'b0;
      latch     = 1'b0;
      ready     = 1'b0;
      sel_hi    = 1'b0;
      ddr_d     = '0;
      ddr_clk_d = '1;

      case (state_q)
         IDLE: begin
            ready = !train_req_i;
            if (train_req_i) begin
               state_d  = TRAIN;
               latch    = 1'b1;
               tcnt_d   = tlen;
               tphase_d = 1'b0;
            end else if (valid_i) begin
               state_d = SEND;
               latch   = 1'b1;
               beat_d  = data_i;
            end
         end
         SEND: begin
            ready = wrap && !train_req_i;
            if (wrap) begin
               if (train_req_i) begin
                  state_d  = TRAIN;
                  tcnt_d   = tlen;
                  tphase_d = 1'b0;
               end else if (valid_i) begin
                  beat_d = data_i;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         TRAIN: begin
            if (wrap) begin
               tcnt_d   = tcnt_q - TrainLenW'(1);
               tphase_d = !tphase_q;
               if (tcnt_q == TrainLenW'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Shadow config only moves when a burst starts from IDLE.
      if (latch) begin
         div_d     = (div_even < CntW'(2)) ? CntW'(2) : div_even;
         start_d   = cfg_shift_start_i;
         end_d     = cfg_shift_end_i;
         ddr_en_d  = cfg_ddr_en_i;
         chan_en_d = cfg_chan_en_i;
      end

      cnt_d = (!active || wrap) ? '0 : cnt_q + CntW'(1);

      // Forcing high on the last step makes every beat end with the clock high.
      clk_d = clk_q;
      if (!active || wrap) begin
         clk_d = 1'b1;
      end else if (cnt_q == start_q || cnt_q == end_q) begin
         clk_d = !clk_q;
      end

      if (active) begin
         for (int c = 0; c < NumChannels; c++) begin
            if (chan_en_q[c]) begin
               ddr_clk_d[c] = clk_d;
               if (state_q == TRAIN) begin
                  sel_hi = ddr_en_q ? (cnt_q >= half) : tphase_q;
                  ddr_d[c*NumLanes +: NumLanes] = sel_hi ? PatAA : Pat55;
               end else begin
                  sel_hi = ddr_en_q && (cnt_q >= half);
                  ddr_d[c*NumLanes +: NumLanes] = sel_hi ? beat_q[c*BeatW+NumLanes +: NumLanes]
                                                         : beat_q[c*BeatW +: NumLanes];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         div_q     <= CntW'(2);
         start_q   <= '0;
         end_q     <= '0;
         ddr_en_q  <= 1'b0;
         chan_en_q <= '0;
         tcnt_q    <= '0;
         tphase_q  <= 1'b0;
         beat_q    <= '0;
         clk_q     <= 1'b1;
         ddr_clk_q <= '1;
         ddr_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         start_q   <= start_d;
         end_q     <= end_d;
         ddr_en_q  <= ddr_en_d;
         chan_en_q <= chan_en_d;
         tcnt_q    <= tcnt_d;
         tphase_q  <= tphase_d;
         beat_q    <= beat_d;
         clk_q     <= clk_d;
         ddr_clk_q <= ddr_clk_d;
         ddr_q     <= ddr_d;
         busy_q    <= active;
         done_q    <= done_d;
      end
   end

   assign ready_o      = ready && !rst_i;
   assign ddr_clk_o    = ddr_clk_q;
   assign ddr_o        = ddr_q;
   assign busy_o       = busy_q;
   assign train_done_o = done_q;

endmodule

// File: tb/tb_serial_link_phy_tx_mc.sv
// Directed bench for serial_link_phy_tx_mc: 2 channels x 8 lanes, inputs driven and outputs sampled on the falling edge.
module tb_serial_link_phy_tx_mc;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [5:0]  cfg_clk_div_i, cfg_shift_start_i, cfg_shift_end_i;
   logic        cfg_ddr_en_i;
   logic [1:0]  cfg_chan_en_i;
   logic        train_req_i;
   logic [7:0]  train_len_i;
   logic [31:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic [1:0]  ddr_clk_o;
   logic [15:0] ddr_o;
   logic        busy_o;
   logic        train_done_o;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk_i = ~clk_i;

   serial_link_phy_tx_mc dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_clk_div_i(cfg_clk_div_i), .cfg_shift_start_i(cfg_shift_start_i),
      .cfg_shift_end_i(cfg_shift_end_i), .cfg_ddr_en_i(cfg_ddr_en_i),
      .cfg_chan_en_i(cfg_chan_en_i), .train_req_i(train_req_i),
      .train_len_i(train_len_i), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .ddr_clk_o(ddr_clk_o), .ddr_o(ddr_o),
      .busy_o(busy_o), .train_done_o(train_done_o)
   );

   task automatic set_cfg(input logic [5:0] div, input logic [5:0] st, input logic [5:0] en_pt,
                          input logic ddr, input logic [1:0] chen);
      cfg_clk_div_i = div; cfg_shift_start_i = st; cfg_shift_end_i = en_pt;
      cfg_ddr_en_i = ddr; cfg_chan_en_i = chen;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; valid_i = 1'b0; train_req_i = 1'b0; train_len_i = '0; data_i = '0;
      set_cfg(6'd4, 6'd0, 6'd2, 1'b1, 2'b11);
      repeat (3) @(negedge clk_i);
      #1;
      cmp_cnt++; if (ready_o !== 1'b0) begin err_cnt++; $display("FAIL rst_ready_during got %b exp 0", ready_o); end
      rst_i = 1'b0;
      #1;
      cmp_cnt++; if (ddr_clk_o !== 2'b11) begin err_cnt++; $display("FAIL rst_clk got %b exp 11", ddr_clk_o); end
      cmp_cnt++; if (ddr_o !== 16'h0) begin err_cnt++; $display("FAIL rst_data got %h exp 0000", ddr_o); end
      cmp_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL rst_ready got %b exp 1", ready_o); end
      cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL rst_busy got %b exp 0", busy_o); end
      cmp_cnt++; if (train_done_o !== 1'b0) begin err_cnt++; $display("FAIL rst_done got %b exp 0", train_done_o); end
   endtask

   task automatic test_ddr_single();
      logic [15:0] exp_d [5];
      logic [1:0]  exp_c [5];
      logic        exp_b [5];
      exp_d = '{16'h343C, 16'h343C, 16'h12A5, 16'h12A5, 16'h0000};
      exp_c = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b11};
      exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      @(negedge clk_i);
      set_cfg(6'd4, 6'd0, 6'd2, 1'b1, 2'b11);
      data_i = 32'h1234_A53C; valid_i = 1'b1;
      #1;
      cmp_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL ddr1_ready got %b exp 1", ready_o); end
      @(negedge clk_i);
      valid_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         cmp_cnt++; if (ddr_o !== exp_d[k]) begin err_cnt++; $display("FAIL ddr1_data k=%0d got %h exp %h", k, ddr_o, exp_d[k]); end
         cmp_cnt++; if (ddr_clk_o !== exp_c[k]) begin err_cnt++; $display("FAIL ddr1_clk k=%0d got %b exp %b", k, ddr_clk_o, exp_c[k]); end
         cmp_cnt++; if (busy_o !== exp_b[k]) begin err_cnt++; $display("FAIL ddr1_busy k=%0d got %b exp %b", k, busy_o, exp_b[k]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] beats [4];
      logic [15:0] exp_d [10];
      logic [1:0]  exp_c [10];
      logic        exp_r [10];
      beats = '{32'hE151_F111, 32'hE252_F222, 32'hE353_F333, 32'hE454_F444};
      exp_d = '{16'h0000, 16'h5111, 16'h5111, 16'h5222, 16'h5222,
                16'h5333, 16'h5333, 16'h5444, 16'h5444, 16'h0000};
      exp_c = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
      exp_r = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      @(negedge clk_i);
      set_cfg(6'd2, 6'd0, 6'd1, 1'b0, 2'b11);
      data_i = beats[0]; valid_i = 1'b1;
      #1;
      cmp_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready_first got %b exp 1", ready_o); end
      for (int n = 0; n < 10; n++) begin
         @(negedge clk_i);
         cmp_cnt++; if (ddr_o !== exp_d[n]) begin err_cnt++; $display("FAIL b2b_data n=%0d got %h exp %h", n, ddr_o, exp_d[n]); end
         cmp_cnt++; if (ddr_clk_o !== exp_c[n]) begin err_cnt++; $display("FAIL b2b_clk n=%0d got %b exp %b", n, ddr_clk_o, exp_c[n]); end
         if (n == 0 || n == 2 || n == 4) data_i = beats[n/2 + 1];
         if (n == 2) begin cfg_clk_div_i = 6'd6; cfg_ddr_en_i = 1'b1; end
         if (n == 6) valid_i = 1'b0;
         #1;
         cmp_cnt++; if (ready_o !== exp_r[n]) begin err_cnt++; $display("FAIL b2b_ready n=%0d got %b exp %b", n, ready_o, exp_r[n]); end
      end
   endtask

   task automatic test_training();
      logic [15:0] ed;
      logic [1:0]  ec;
      int          dcnt = 0;
      int          dpos = -1;
      @(negedge clk_i);
      set_cfg(6'd4, 6'd0, 6'd2, 1'b1, 2'b11);
      train_req_i = 1'b1; train_len_i = 8'd3; valid_i = 1'b0;
      #1;
      cmp_cnt++; if (ready_o !== 1'b0) begin err_cnt++; $display("FAIL trn_ready_req got %b exp 0", ready_o); end
      for (int n = 0; n < 14; n++) begin
         @(negedge clk_i);
         if (n == 0) train_req_i = 1'b0;
         ed = 16'h0000; ec = 2'b11;
         if (n >= 1 && n <= 12) begin
            ed = (((n - 1) % 4) < 2) ? 16'h5555 : 16'hAAAA;
            ec = (((n - 1) % 4) < 2) ? 2'b00 : 2'b11;
         end
         cmp_cnt++; if (ddr_o !== ed) begin err_cnt++; $display("FAIL trn_data n=%0d got %h exp %h", n, ddr_o, ed); end
         cmp_cnt++; if (ddr_clk_o !== ec) begin err_cnt++; $display("FAIL trn_clk n=%0d got %b exp %b", n, ddr_clk_o, ec); end
         #1;
         if (n <= 11) begin
            cmp_cnt++; if (ready_o !== 1'b0) begin err_cnt++; $display("FAIL trn_ready n=%0d got %b exp 0", n, ready_o); end
         end
         if (train_done_o === 1'b1) begin dcnt++; dpos = n; end
      end
      cmp_cnt++; if (dcnt != 1) begin err_cnt++; $display("FAIL trn_done_count got %0d exp 1", dcnt); end
      cmp_cnt++; if (dpos != 12) begin err_cnt++; $display("FAIL trn_done_pos got %0d exp 12", dpos); end
      cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL trn_busy_end got %b exp 0", busy_o); end
   endtask

   task automatic test_train_short();
      logic [15:0] ed;
      int          dcnt = 0;
      int          dpos = -1;
      // train_len 0 gives exactly one DDR beat
      @(negedge clk_i);
      set_cfg(6'd4, 6'd0, 6'd2, 1'b1, 2'b11);
      train_req_i = 1'b1; train_len_i = 8'd0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk_i);
         if (n == 0) train_req_i = 1'b0;
         ed = (n == 1 || n == 2) ? 16'h5555 : (n == 3 || n == 4) ? 16'hAAAA : 16'h0000;
         cmp_cnt++; if (ddr_o !== ed) begin err_cnt++; $display("FAIL trn0_data n=%0d got %h exp %h", n, ddr_o, ed); end
         if (train_done_o === 1'b1) begin dcnt++; dpos = n; end
      end
      cmp_cnt++; if (dcnt != 1 || dpos != 4) begin err_cnt++; $display("FAIL trn0_done got count %0d pos %0d exp 1 at 4", dcnt, dpos); end
      // SDR training alternates 55/AA per beat
      dcnt = 0; dpos = -1;
      @(negedge clk_i);
      set_cfg(6'd2, 6'd0, 6'd1, 1'b0, 2'b11);
      train_req_i = 1'b1; train_len_i = 8'd2;
      for (int n = 0; n < 7; n++) begin
         @(negedge clk_i);
         if (n == 0) train_req_i = 1'b0;
         ed = (n == 1 || n == 2) ? 16'h5555 : (n == 3 || n == 4) ? 16'hAAAA : 16'h0000;
         cmp_cnt++; if (ddr_o !== ed) begin err_cnt++; $display("FAIL trnsdr_data n=%0d got %h exp %h", n, ddr_o, ed); end
         if (train_done_o === 1'b1) begin dcnt++; dpos = n; end
      end
      cmp_cnt++; if (dcnt != 1 || dpos != 4) begin err_cnt++; $display("FAIL trnsdr_done got count %0d pos %0d exp 1 at 4", dcnt, dpos); end
   endtask

   task automatic test_priority_enable();
      logic [15:0] exp_d [7];
      logic [1:0]  exp_c [7];
      logic        exp_r [7];
      logic        exp_t [7];
      exp_d = '{16'h0000, 16'h0055, 16'h00AA, 16'h0000, 16'h007E, 16'h00C3, 16'h0000};
      exp_c = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11};
      exp_r = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      @(negedge clk_i);
      set_cfg(6'd2, 6'd0, 6'd1, 1'b1, 2'b01);
      train_req_i = 1'b1; train_len_i = 8'd1; valid_i = 1'b1; data_i = 32'hBEEF_C37E;
      #1;
      cmp_cnt++; if (ready_o !== 1'b0) begin err_cnt++; $display("FAIL pri_ready_pre got %b exp 0", ready_o); end
      for (int n = 0; n < 7; n++) begin
         @(negedge clk_i);
         if (n == 0) train_req_i = 1'b0;
         if (n == 3) valid_i = 1'b0;
         cmp_cnt++; if (ddr_o !== exp_d[n]) begin err_cnt++; $display("FAIL pri_data n=%0d got %h exp %h", n, ddr_o, exp_d[n]); end
         cmp_cnt++; if (ddr_clk_o !== exp_c[n]) begin err_cnt++; $display("FAIL pri_clk n=%0d got %b exp %b", n, ddr_clk_o, exp_c[n]); end
         cmp_cnt++; if (train_done_o !== exp_t[n]) begin err_cnt++; $display("FAIL pri_done n=%0d got %b exp %b", n, train_done_o, exp_t[n]); end
         #1;
         cmp_cnt++; if (ready_o !== exp_r[n]) begin err_cnt++; $display("FAIL pri_ready n=%0d got %b exp %b", n, ready_o, exp_r[n]); end
      end
   endtask

   task automatic test_clamp();
      logic [15:0] exp_d [5];
      logic [1:0]  exp_c [5];
      // div 1 clamps to 2-cycle beats
      exp_d = '{16'h8866, 16'h7799, 16'h0000, 16'h0000, 16'h0000};
      exp_c = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
      @(negedge clk_i);
      set_cfg(6'd1, 6'd0, 6'd1, 1'b1, 2'b11);
      data_i = 32'h7788_9966; valid_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         cmp_cnt++; if (ddr_o !== exp_d[k]) begin err_cnt++; $display("FAIL clamp1_data k=%0d got %h exp %h", k, ddr_o, exp_d[k]); end
         cmp_cnt++; if (ddr_clk_o !== exp_c[k]) begin err_cnt++; $display("FAIL clamp1_clk k=%0d got %b exp %b", k, ddr_clk_o, exp_c[k]); end
      end
      // div 5 rounds down to 4
      exp_d = '{16'h8866, 16'h8866, 16'h7799, 16'h7799, 16'h0000};
      exp_c = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b11};
      @(negedge clk_i);
      set_cfg(6'd5, 6'd0, 6'd2, 1'b1, 2'b11);
      valid_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         cmp_cnt++; if (ddr_o !== exp_d[k]) begin err_cnt++; $display("FAIL clamp5_data k=%0d got %h exp %h", k, ddr_o, exp_d[k]); end
         cmp_cnt++; if (ddr_clk_o !== exp_c[k]) begin err_cnt++; $display("FAIL clamp5_clk k=%0d got %b exp %b", k, ddr_clk_o, exp_c[k]); end
      end
   endtask

   task automatic test_abort();
      int dcnt = 0;
      @(negedge clk_i);
      set_cfg(6'd4, 6'd0, 6'd2, 1'b1, 2'b11);
      train_req_i = 1'b1; train_len_i = 8'd5; valid_i = 1'b0;
      @(negedge clk_i);
      train_req_i = 1'b0;
      repeat (3) @(negedge clk_i);
      cmp_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL abort_busy_mid got %b exp 1", busy_o); end
      rst_i = 1'b1;
      @(negedge clk_i);
      cmp_cnt++; if (ddr_clk_o !== 2'b11) begin err_cnt++; $display("FAIL abort_clk got %b exp 11", ddr_clk_o); end
      cmp_cnt++; if (ddr_o !== 16'h0) begin err_cnt++; $display("FAIL abort_data got %h exp 0000", ddr_o); end
      cmp_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL abort_busy got %b exp 0", busy_o); end
      cmp_cnt++; if (ready_o !== 1'b0) begin err_cnt++; $display("FAIL abort_ready_rst got %b exp 0", ready_o); end
      if (train_done_o === 1'b1) dcnt++;
      rst_i = 1'b0;
      #1;
      cmp_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL abort_ready got %b exp 1", ready_o); end
      repeat (25) begin
         @(negedge clk_i);
         if (train_done_o === 1'b1) dcnt++;
      end
      cmp_cnt++; if (dcnt != 0) begin err_cnt++; $display("FAIL abort_done got %0d pulses exp 0", dcnt); end
      cmp_cnt++; if (ddr_o !== 16'h0 || ddr_clk_o !== 2'b11) begin err_cnt++; $display("FAIL abort_idle got %h/%b exp 0000/11", ddr_o, ddr_clk_o); end
   endtask

   initial begin
      test_reset();
      test_ddr_single();
      test_back_to_back();
      test_training();
      test_train_short();
      test_priority_enable();
      test_clamp();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
